insfetch: RTL and testbench

- Instruction fetch stage directly upstream of insdecoder.
- Holds the 16-bit PC and fetches one 1024-bit VLIW word from instruction memory as BEATS narrow read beats.
- Assembles the beats and presents the word to the decoder over a valid/ready handshake.
- Accepts a PC redirect (jump target or decoder `next` field) from downstream; a redirect aborts any fetch in flight.

---
 rtl/insfetch_pkg.sv | 46 ++++
 rtl/insfetch_beat_asm.sv | 36 +++
 rtl/insfetch.sv | 199 +++++++++++++++++++
 tb/tb_insfetch.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/insfetch_pkg.sv
// insfetch_pkg: shared widths, fetch state encoding and sizing helpers for
// the instruction fetch stage (and the insdecoder that consumes its output).
package insfetch_pkg;

  // Default widths shared with insdecoder.
  localparam int DEF_INS_W  = 1024;
  localparam int DEF_BEAT_W = 128;
  localparam int DEF_PC_W   = 16;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } fetch_state_e;

  // Number of memory beats that make up one instruction word.
  function automatic int calc_beats(input int ins_w, input int beat_w);
    return ins_w / beat_w;
  endfunction

  // Beat index width; never below one bit so a single-beat build still has an index.
  function automatic int calc_bi_w(input int beats);
    int res;
    if (beats > 1) begin
      res = $clog2(beats);
    end else begin
      res = 1;
    end
    return res;
  endfunction

  // Saturating 32-bit increment used by the event counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] cnt, input logic en);
    logic [31:0] res;
    if (en && (cnt != 32'hFFFF_FFFF)) begin
      res = cnt + 32'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/insfetch_beat_asm.sv
// ins_beat_asm: assembles narrow memory beats into one wide instruction word.
// Beat 0 lands in the least significant lanes. clr wipes the whole buffer.
module ins_beat_asm
  import insfetch_pkg::*;
#(
  parameter int INS_W  = DEF_INS_W,
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int BI_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [BI_W-1:0]   wr_idx,
  input  logic [BEAT_W-1:0] wr_data,
  output logic [INS_W-1:0]  word_out
);

  logic [INS_W-1:0] buf_r;

  // Word buffer: clear has priority over a beat write; otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_r <= {INS_W{1'b0}};
    end else if (clr) begin
      buf_r <= {INS_W{1'b0}};
    end else if (wr_en) begin
      buf_r[wr_idx*BEAT_W +: BEAT_W] <= wr_data;
    end else begin
      buf_r <= buf_r;
    end
  end

  assign word_out = buf_r;

endmodule

// File: rtl/insfetch.sv
// insfetch: instruction fetch stage. Reads one INS_W word as BEATS narrow
// beats, presents it over valid/ready, and honours PC redirects that abort
// any fetch in flight.
// Optional build macro INSFETCH_PERF_EN adds saturating perf_fetched and
// perf_stall counters as extra output ports.
module insfetch
  import insfetch_pkg::*;
#(
  parameter int             INS_W    = DEF_INS_W,
  parameter int             BEAT_W   = DEF_BEAT_W,
  parameter int             PC_W     = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
  localparam int            BEATS    = calc_beats(INS_W, BEAT_W),
  localparam int            BI_W     = calc_bi_w(BEATS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 redirect_valid,
  input  logic [PC_W-1:0]      redirect_addr,
  output logic                 mem_req,
  output logic [PC_W+BI_W-1:0] mem_addr,
  input  logic [BEAT_W-1:0]    mem_rdata,
  input  logic                 mem_rvalid,
  output logic [INS_W-1:0]     ins,
  output logic                 ins_valid,
  input  logic                 ins_ready,
  output logic [PC_W-1:0]      pc_out
`ifdef INSFETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_stall
`endif
);

  fetch_state_e    state_r, state_nx;
  logic [PC_W-1:0] pc_r, pc_nx;
  logic [BI_W-1:0] bi_r, bi_nx;
  logic            ins_valid_r;
  logic            buf_we_s;
  logic            buf_clr_s;
  logic            hs_s;
  logic            last_beat_s;

  assign hs_s        = (state_r == ST_HOLD) && ins_ready;
  assign last_beat_s = (bi_r == BI_W'(BEATS - 1));

  // Next-state, PC and beat-index selection; a redirect always wins.
  always_comb begin
    state_nx  = state_r;
    pc_nx     = pc_r;
    bi_nx     = bi_r;
    buf_we_s  = 1'b0;
    buf_clr_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (redirect_valid) begin
          pc_nx = redirect_addr;
          bi_nx = {BI_W{1'b0}};
        end else if (run) begin
          state_nx = ST_REQ;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (redirect_valid) begin
          pc_nx     = redirect_addr;
          bi_nx     = {BI_W{1'b0}};
          buf_clr_s = 1'b1;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_nx     = redirect_addr;
          bi_nx     = {BI_W{1'b0}};
          buf_clr_s = 1'b1;
          // A beat arriving together with the redirect is simply dropped;
          // otherwise the stale beat is still owed and must be drained.
          if (mem_rvalid) begin
            state_nx = ST_REQ;
          end else begin
            state_nx = ST_DRAIN;
          end
        end else if (mem_rvalid) begin
          buf_we_s = 1'b1;
          if (last_beat_s) begin
            bi_nx    = {BI_W{1'b0}};
            state_nx = ST_HOLD;
          end else begin
            bi_nx    = bi_r + BI_W'(1);
            state_nx = ST_REQ;
          end
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (redirect_valid) begin
          pc_nx     = redirect_addr;
          bi_nx     = {BI_W{1'b0}};
          buf_clr_s = 1'b1;
        end else begin
          pc_nx = pc_r;
        end
        // The stale beat is consumed whenever it shows up, even alongside a
        // fresh redirect, so the stage never waits for a beat that is not coming.
        if (mem_rvalid) begin
          if (run) begin
            state_nx = ST_REQ;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          state_nx = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          // Word is either accepted (ins_ready) or dropped; both restart at the target.
          pc_nx     = redirect_addr;
          bi_nx     = {BI_W{1'b0}};
          buf_clr_s = 1'b1;
          state_nx  = ST_REQ;
        end else if (hs_s) begin
          pc_nx = pc_r + PC_W'(1);
          if (run) begin
            state_nx = ST_REQ;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          state_nx = ST_HOLD;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Sequencer, PC, beat index and registered valid flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      pc_r        <= RESET_PC;
      bi_r        <= {BI_W{1'b0}};
      ins_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      pc_r        <= pc_nx;
      bi_r        <= bi_nx;
      ins_valid_r <= (state_nx == ST_HOLD);
    end
  end

  ins_beat_asm #(
    .INS_W  (INS_W),
    .BEAT_W (BEAT_W),
    .BI_W   (BI_W)
  ) u_beat_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (buf_clr_s),
    .wr_en    (buf_we_s),
    .wr_idx   (bi_r),
    .wr_data  (mem_rdata),
    .word_out (ins)
  );

  // Beat request is a pure decode of REQ, withheld while a redirect lands.
  assign mem_req   = (state_r == ST_REQ) && !redirect_valid;
  assign mem_addr  = (state_r == ST_REQ) ? {pc_r, bi_r} : {(PC_W + BI_W){1'b0}};
  assign ins_valid = ins_valid_r;
  assign pc_out    = pc_r;

`ifdef INSFETCH_PERF_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_stall_r;

  // Saturating counts of delivered words and memory-wait cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_r <= 32'd0;
      perf_stall_r   <= 32'd0;
    end else begin
      perf_fetched_r <= sat_inc32(perf_fetched_r, hs_s);
      perf_stall_r   <= sat_inc32(perf_stall_r,
                                  (state_r == ST_WAIT) || (state_r == ST_DRAIN));
    end
  end

  assign perf_fetched = perf_fetched_r;
  assign perf_stall   = perf_stall_r;
`endif

endmodule

// File: tb/tb_insfetch.sv
// tb_insfetch: directed plus randomized bench for insfetch. A behavioural
// memory answers each request after a programmable latency with beat data
// derived from the address; expected words and PCs come from plain arithmetic.
module tb_insfetch;

  logic           clk;
  logic           rst_n;
  logic           run;
  logic           redirect_valid;
  logic [15:0]    redirect_addr;
  logic           mem_req;
  logic [18:0]    mem_addr;
  logic [127:0]   mem_rdata;
  logic           mem_rvalid;
  logic [1023:0]  ins;
  logic           ins_valid;
  logic           ins_ready;
  logic [15:0]    pc_out;
`ifdef INSFETCH_PERF_EN
  logic [31:0]    perf_fetched;
  logic [31:0]    perf_stall;
`endif

  int chk_cnt = 0;
  int err_cnt = 0;

  // memory model controls
  int mem_lat  = 1;
  bit mem_rand = 1'b0;

  insfetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_rvalid     (mem_rvalid),
    .ins            (ins),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .pc_out         (pc_out)
`ifdef INSFETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: requests are taken at the rising edge, beats are driven at the
  // falling edge 'latency' cycles later.
  int       req_seq = 0;
  logic [7:0] req_byte;
  int       req_lat;

  always @(posedge clk) begin
    if (mem_req) begin
      req_byte = mem_addr[7:0];
      req_lat  = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
      req_seq  = req_seq + 1;
    end
  end

  int       seq_seen = 0;
  int       mem_cnt  = 0;
  logic [7:0] beat_byte;
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 128'd0;
  end
  always @(negedge clk) begin
    if (req_seq != seq_seen) begin
      seq_seen  = req_seq;
      mem_cnt   = req_lat;
      beat_byte = req_byte;
    end
    mem_rvalid = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = {16{beat_byte}};
      end
    end
  end

  // Expected word for a PC: beat k is byte (pc*8+k) replicated across its lane.
  function automatic logic [1023:0] exp_word(input logic [15:0] pc);
    logic [1023:0] w;
    logic [7:0]    b;
    for (int k = 0; k < 8; k++) begin
      b = 8'(pc * 8 + k);
      w[k*128 +: 128] = {16{b}};
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [1023:0] exp);
    logic [1023:0] got;
    got = ins;
    for (int k = 0; k < 8; k++) begin
      check(tag, got[k*128 +: 128], exp[k*128 +: 128]);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ins_valid && n < 300);
    check({tag, "_seen"}, ins_valid, 1);
  endtask

  task automatic wait_req(input string tag, input bit any, input logic [2:0] beat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req && (any || mem_addr[2:0] == beat)) && n < 300);
    check({tag, "_seen"}, mem_req, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int            n;
    int            words;
    int            cyc;
    logic [15:0]   exp_pc;
    logic [1023:0] held;

    rst_n          = 1'b0;
    run            = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 16'h0000;
    ins_ready      = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_valid", ins_valid, 0);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_pc", pc_out, 16'h0000);
    check_word("rst_ins", {1024{1'b0}});
    rst_n = 1'b1;
    @(negedge clk);

    // basic fetch and first-word latency
    ins_ready = 1'b1;
    run       = 1'b1;
    @(negedge clk);
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 19'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ins_valid && n < 100);
    check("latency", n, 16);
    check("w0_pc", pc_out, 16'h0000);
    check_word("w0_ins", exp_word(16'h0000));
    wait_valid("w1");
    check("w1_pc", pc_out, 16'h0001);
    check_word("w1_ins", exp_word(16'h0001));
    @(negedge clk);
    ins_ready = 1'b0;

    // backpressure on word 2
    wait_valid("bp");
    held = ins;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", ins_valid, 1);
      check("bp_pc", pc_out, 16'h0002);
      check_word("bp_ins", held);
      check("bp_noreq", mem_req, 0);
    end
    check_word("bp_data", exp_word(16'h0002));
    ins_ready = 1'b1;
    @(negedge clk);
    ins_ready = 1'b0;
    check("bp_after_valid", ins_valid, 0);
    check("bp_after_pc", pc_out, 16'h0003);

    // redirect while waiting on beat 3 with a slow memory
    mem_lat = 3;
    wait_req("rd_b3", 1'b0, 3'd3);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_addr  = 16'h0040;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("rd_drain_noreq", mem_req, 0);
    wait_req("rd_next", 1'b1, 3'd0);
    check("rd_next_addr", mem_addr, {16'h0040, 3'd0});
    wait_valid("rd_word");
    check("rd_pc", pc_out, 16'h0040);
    check_word("rd_ins", exp_word(16'h0040));

    // redirect together with handshake
    mem_lat        = 1;
    ins_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 16'h1234;
    @(negedge clk);
    ins_ready      = 1'b0;
    redirect_valid = 1'b0;
    check("rh_valid", ins_valid, 0);
    check("rh_pc", pc_out, 16'h1234);
    wait_valid("rh_word");
    check("rh_word_pc", pc_out, 16'h1234);
    check_word("rh_ins", exp_word(16'h1234));

    // drop held word by redirect, then PC wrap
    redirect_valid = 1'b1;
    redirect_addr  = 16'hFFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("drop_valid", ins_valid, 0);
    wait_valid("wrap_w");
    check("wrap_pc", pc_out, 16'hFFFF);
    check_word("wrap_ins", exp_word(16'hFFFF));
    ins_ready = 1'b1;
    @(negedge clk);
    ins_ready = 1'b0;
    check("wrap_next_pc", pc_out, 16'h0000);
    wait_valid("wrap_w0");
    check("wrap_w0_pc", pc_out, 16'h0000);
    check_word("wrap_w0_ins", exp_word(16'h0000));

    // randomized traffic: random latency, ready and redirects
    mem_rand = 1'b1;
    exp_pc   = 16'h0000;
    words    = 0;
    cyc      = 0;
    while (words < 24 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      redirect_valid = 1'b0;
      ins_ready      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1'b1;
        redirect_addr  = 16'($urandom);
      end
      if (ins_valid && ins_ready) begin
        check("rnd_pc", pc_out, exp_pc);
        check_word("rnd_ins", exp_word(exp_pc));
        words++;
        exp_pc = exp_pc + 16'd1;
      end
      if (redirect_valid) begin
        exp_pc = redirect_addr;
      end
    end
    check("rnd_words", words, 24);
    redirect_valid = 1'b0;
    ins_ready      = 1'b1;
    mem_rand       = 1'b0;

    // reset while waiting on a beat; the late beat must be ignored
    mem_lat = 3;
    wait_req("rw_req", 1'b1, 3'd0);
    @(negedge clk);
    rst_n     = 1'b0;
    run       = 1'b0;
    ins_ready = 1'b0;
    @(negedge clk);
    check("rw_valid", ins_valid, 0);
    check("rw_req0", mem_req, 0);
    check("rw_addr", mem_addr, 0);
    check("rw_pc", pc_out, 16'h0000);
    check_word("rw_ins", {1024{1'b0}});
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rw_idle_valid", ins_valid, 0);
    check("rw_idle_req", mem_req, 0);
    check_word("rw_late_ins", {1024{1'b0}});

    // three words with 2-cycle memory; run drops during the third fetch
    mem_lat   = 2;
    ins_ready = 1'b1;
    run       = 1'b1;
    wait_valid("p0");
    check("p0_pc", pc_out, 16'h0000);
    check_word("p0_ins", exp_word(16'h0000));
    wait_valid("p1");
    check("p1_pc", pc_out, 16'h0001);
    @(negedge clk);
    run = 1'b0;
    wait_valid("p2");
    check("p2_pc", pc_out, 16'h0002);
    check_word("p2_ins", exp_word(16'h0002));
    @(negedge clk);
    check("stop_valid", ins_valid, 0);
    check("stop_req", mem_req, 0);
    @(negedge clk);
    check("stop_idle_req", mem_req, 0);
    check("stop_pc", pc_out, 16'h0003);
`ifdef INSFETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'd3);
    check("perf_stall", perf_stall, 32'd48);
`endif

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
